uart_rx_port: RTL and testbench

UART_RX_PORT -- requirements
Module: uart_rx_port

---
 rtl/uart_rx_port.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_port.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_port.sv
// rtl/uart_rx_port.sv - 8N1 UART receiver with a one-byte ack handshake, framing/overrun flags
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_port #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RX,
    output logic [7:0] UART_RX,
    output logic       UART_RX_valid,
    input  logic       UART_RX_ack,
    output logic       framing_error,
    output logic       overrun,
    output logic       parity_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    // The IDLE cycle that sees the falling edge counts toward the half bit.
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [3:0]       ARM_BITS_LAST = 4'd9;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd5;
`endif

    logic             r_sync1;
    logic             r_rx_s;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [3:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_armed;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_framing_error;
    logic             r_overrun;

    logic w_bit_tick;
    logic w_stop_sample;
    logic w_frame_fail;
    logic w_byte_done;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= RX;
            r_rx_s  <= r_sync1;
        end
    end

    assign w_bit_tick    = (r_clk_cnt == CNT_BIT_LAST);
    assign w_stop_sample = (r_state == S_STOP) && w_bit_tick;
    assign w_frame_fail  = w_stop_sample && !r_rx_s;

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_error;
    logic w_par_mismatch;
    logic w_par_fail;

    assign w_par_mismatch = ((^r_shift) != r_par_bit);
    assign w_byte_done    = w_stop_sample && r_rx_s && !w_par_mismatch;
    assign w_par_fail     = w_stop_sample && r_rx_s && w_par_mismatch;
`else
    assign w_byte_done    = w_stop_sample && r_rx_s;
`endif

    // r_armed holds off frame detection after reset until the line has been
    // high for a whole frame time, so a frame cut by reset cannot resync mid-byte.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_armed   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_armed) begin
                        if (!r_rx_s) begin
                            r_clk_cnt <= '0;
                            r_bit_cnt <= 4'd0;
                        end else if (w_bit_tick) begin
                            r_clk_cnt <= '0;
                            if (r_bit_cnt == ARM_BITS_LAST) begin
                                r_bit_cnt <= 4'd0;
                                r_armed   <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end else begin
                            r_clk_cnt <= r_clk_cnt + CNT_ONE;
                        end
                    end else if (!r_rx_s) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= 4'd0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (r_clk_cnt == CNT_HALF_LAST) begin
                        r_clk_cnt <= '0;
                        r_state   <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (w_bit_tick) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        if (r_bit_cnt == 4'd7) begin
                            r_bit_cnt <= 4'd0;
`ifdef UART_RX_PARITY_EN
                            r_state   <= S_PARITY;
`else
                            r_state   <= S_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_tick) begin
                        r_clk_cnt <= '0;
                        r_par_bit <= r_rx_s;
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_tick) begin
                        r_clk_cnt <= '0;
                        r_state   <= r_rx_s ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
                S_WAIT_HIGH: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_clk_cnt <= '0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // A completion that meets an ack in the same cycle replaces the byte and keeps valid high.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_data          <= 8'h00;
            r_valid         <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_framing_error <= w_frame_fail;
            if (w_byte_done && (!r_valid || UART_RX_ack)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (UART_RX_ack) begin
                r_valid <= 1'b0;
            end
            if (w_byte_done && r_valid && !UART_RX_ack) begin
                r_overrun <= 1'b1;
            end else if (UART_RX_ack) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_parity_error <= 1'b0;
        end else begin
            r_parity_error <= w_par_fail;
        end
    end

    assign parity_error = r_parity_error;
`else
    assign parity_error = 1'b0;
`endif

    assign UART_RX       = r_data;
    assign UART_RX_valid = r_valid;
    assign framing_error = r_framing_error;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_uart_rx_port.sv
// tb/tb_uart_rx_port.sv - directed self-checking bench for uart_rx_port at CLKS_PER_BIT=8
module tb_uart_rx_port;

    localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int LAT      = 86;
    localparam int PE_TOTAL = 1;
`else
    localparam int LAT      = 78;
    localparam int PE_TOTAL = 0;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic       RX;
    logic [7:0] UART_RX;
    logic       UART_RX_valid;
    logic       UART_RX_ack;
    logic       framing_error;
    logic       overrun;
    logic       parity_error;

    int   cyc = 0;
    int   fall_cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   rise_cnt = 0;
    int   fe_cnt = 0;
    int   pe_cnt = 0;
    logic prev_valid = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_port #(.CLKS_PER_BIT(CPB)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .RX            (RX),
        .UART_RX       (UART_RX),
        .UART_RX_valid (UART_RX_valid),
        .UART_RX_ack   (UART_RX_ack),
        .framing_error (framing_error),
        .overrun       (overrun),
        .parity_error  (parity_error)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        prev_valid <= UART_RX_valid;
        if (UART_RX_valid && !prev_valid) rise_cnt <= rise_cnt + 1;
        if (framing_error) fe_cnt <= fe_cnt + 1;
        if (parity_error) pe_cnt <= pe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic ack_pulse();
        UART_RX_ack = 1'b1;
        @(posedge CLK);
        #1;
        UART_RX_ack = 1'b0;
    endtask

    // Called one step after a rising edge; leaves the line high (or low for extra_low cycles first).
    task automatic send_frame(input logic [7:0] b, input logic stop_b, input int extra_low);
        RX = 1'b0;
        fall_cyc = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge CLK);
            #1;
            RX = b[i];
        end
`ifdef UART_RX_PARITY_EN
        repeat (CPB) @(posedge CLK);
        #1;
        RX = (^b) ^ par_flip;
`endif
        repeat (CPB) @(posedge CLK);
        #1;
        RX = stop_b;
        repeat (CPB) @(posedge CLK);
        #1;
        if (extra_low > 0) begin
            RX = 1'b0;
            repeat (extra_low) @(posedge CLK);
            #1;
        end
        RX = 1'b1;
    endtask

    initial begin
        int seen;
        int lat;
        int b_rise;
        int b_fe;

        RESET = 1'b1;
        RX = 1'b1;
        UART_RX_ack = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_data", 32'(UART_RX), 32'h00);
        check("rst_valid", 32'(UART_RX_valid), 32'd0);
        check("rst_ferr", 32'(framing_error), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_perr", 32'(parity_error), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        idle(100);

        seen = 0;
        lat = 0;
        fork
            send_frame(8'h50, 1'b1, 0);
            begin
                for (int i = 0; i < 200 && seen == 0; i++) begin
                    @(negedge CLK);
                    if (UART_RX_valid) begin
                        seen = 1;
                        lat = cyc - fall_cyc;
                    end
                end
                @(posedge CLK);
                #1;
                UART_RX_ack = 1'b1;
                @(posedge CLK);
                #1;
                UART_RX_ack = 1'b0;
            end
        join
        check("b50_seen", 32'(seen), 32'd1);
        check("b50_latency", 32'(lat), 32'(LAT));
        @(negedge CLK);
        check("b50_data", 32'(UART_RX), 32'h50);
        check("b50_ack_valid", 32'(UART_RX_valid), 32'd0);
        check("b50_overrun", 32'(overrun), 32'd0);

        idle(10);
        b_rise = rise_cnt;
        send_frame(8'h41, 1'b1, 0);
        send_frame(8'h0D, 1'b1, 0);
        idle(5);
        check("bb_rises", 32'(rise_cnt - b_rise), 32'd1);
        check("bb_data", 32'(UART_RX), 32'h41);
        check("bb_valid", 32'(UART_RX_valid), 32'd1);
        check("bb_overrun", 32'(overrun), 32'd1);
        ack_pulse();
        check("bb_ack_valid", 32'(UART_RX_valid), 32'd0);
        check("bb_ack_overrun", 32'(overrun), 32'd0);
        check("bb_ack_data", 32'(UART_RX), 32'h41);

        idle(10);
        send_frame(8'h41, 1'b1, 0);
        idle(5);
        fork
            send_frame(8'h0D, 1'b1, 0);
            begin
                repeat (LAT - 1) @(posedge CLK);
                #1;
                UART_RX_ack = 1'b1;
                @(posedge CLK);
                #1;
                UART_RX_ack = 1'b0;
            end
        join
        idle(3);
        check("co_data", 32'(UART_RX), 32'h0D);
        check("co_valid", 32'(UART_RX_valid), 32'd1);
        check("co_overrun", 32'(overrun), 32'd0);
        ack_pulse();
        check("co_ack_valid", 32'(UART_RX_valid), 32'd0);

        idle(10);
        b_fe = fe_cnt;
        b_rise = rise_cnt;
        send_frame(8'h0D, 1'b0, 40);
        idle(30);
        check("fe_pulses", 32'(fe_cnt - b_fe), 32'd1);
        check("fe_rises", 32'(rise_cnt - b_rise), 32'd0);
        check("fe_valid", 32'(UART_RX_valid), 32'd0);
        send_frame(8'h50, 1'b1, 0);
        idle(5);
        check("fe_next_data", 32'(UART_RX), 32'h50);
        check("fe_next_valid", 32'(UART_RX_valid), 32'd1);
        ack_pulse();

        idle(10);
        b_fe = fe_cnt;
        b_rise = rise_cnt;
        RX = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RX = 1'b1;
        idle(100);
        check("gl_rises", 32'(rise_cnt - b_rise), 32'd0);
        check("gl_ferr", 32'(fe_cnt - b_fe), 32'd0);
        check("gl_valid", 32'(UART_RX_valid), 32'd0);

        idle(10);
        b_fe = fe_cnt;
        b_rise = rise_cnt;
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                repeat (44) @(posedge CLK);
                #1;
                RESET = 1'b1;
                #2;
                check("mr_rst_data", 32'(UART_RX), 32'h00);
                @(posedge CLK);
                #1;
                RESET = 1'b0;
            end
        join
        idle(120);
        send_frame(8'h3C, 1'b1, 0);
        idle(5);
        check("mr_rises", 32'(rise_cnt - b_rise), 32'd1);
        check("mr_data", 32'(UART_RX), 32'h3C);
        check("mr_ferr", 32'(fe_cnt - b_fe), 32'd0);
        ack_pulse();

`ifdef UART_RX_PARITY_EN
        idle(10);
        b_rise = rise_cnt;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, 0);
        par_flip = 1'b0;
        idle(5);
        check("par_bad_rises", 32'(rise_cnt - b_rise), 32'd0);
        check("par_bad_valid", 32'(UART_RX_valid), 32'd0);
        send_frame(8'h07, 1'b1, 0);
        idle(5);
        check("par_ok_data", 32'(UART_RX), 32'h07);
        check("par_ok_valid", 32'(UART_RX_valid), 32'd1);
        ack_pulse();
`endif
        idle(5);
        check("perr_total", 32'(pe_cnt), 32'(PE_TOTAL));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
